demux16_capture: RTL and testbench

DEMUX16_CAPTURE -- requirements
Module: demux16_capture

---
 rtl/demux16_capture.sv | 121 ++++++++++++
 tb/tb_demux16_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux16_capture.sv
// Serial-to-16-slot demultiplexer with addressed writes and a 16-bit auto-scan frame capture.
// Optional sticky overrun flag when DEMUX16_OVERRUN_EN is defined.
module demux16_capture #(
    parameter logic [15:0] INIT_Y = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic [3:0]  sel,
    input  logic        scan_start,
    input  logic        abort,
    input  logic        done_ack,
    output logic [15:0] y,
    output logic [15:0] frame,
    output logic [3:0]  idx,
    output logic        busy,
    output logic        done
`ifdef DEMUX16_OVERRUN_EN
    ,
    output logic        overrun
`endif
);

    localparam int unsigned W  = 16;
    localparam int unsigned IW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [W-1:0]    y_d, frame_d;
    logic [IW-1:0]   idx_d;

    // Next-state and next-data decode
    always_comb begin
        state_d = state;
        y_d     = y;
        frame_d = frame;
        idx_d   = idx;
        case (state)
            IDLE: begin
                if (scan_start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end else if (din_valid) begin
                    y_d[sel] = din;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (din_valid) begin
                    y_d[idx] = din;
                    idx_d    = idx + IW'(1);
                    // Last slot: the snapshot includes the bit written on this same edge
                    if (idx == IW'(W - 1)) begin
                        frame_d = y_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (done_ack) begin
                    idx_d   = '0;
                    state_d = scan_start ? SCAN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State and registered outputs; busy/done decode the incoming state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            y     <= INIT_Y;
            frame <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            y     <= y_d;
            frame <= frame_d;
            idx   <= idx_d;
            busy  <= (state_d == SCAN);
            done  <= (state_d == DONE);
        end
    end

`ifdef DEMUX16_OVERRUN_EN
    logic overrun_d;

    // Sticky: acknowledge clears and wins over a same-cycle overrun
    always_comb begin
        overrun_d = overrun;
        if (done_ack) begin
            overrun_d = 1'b0;
        end else if ((state == DONE) && din_valid) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun_d;
        end
    end
`endif

endmodule

// File: tb/tb_demux16_capture.sv
// Self-checking bench for demux16_capture: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_demux16_capture;

    localparam logic [15:0] TB_INIT = 16'h0000;
    localparam int P_IDLE = 0;
    localparam int P_SCAN = 1;
    localparam int P_DONE = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        din, din_valid, scan_start, abort, done_ack;
    logic [3:0]  sel;
    logic [15:0] y, frame;
    logic [3:0]  idx;
    logic        busy, done;
`ifdef DEMUX16_OVERRUN_EN
    logic        overrun;
`endif

    demux16_capture #(.INIT_Y(TB_INIT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .sel        (sel),
        .scan_start (scan_start),
        .abort      (abort),
        .done_ack   (done_ack),
        .y          (y),
        .frame      (frame),
        .idx        (idx),
        .busy       (busy),
        .done       (done)
`ifdef DEMUX16_OVERRUN_EN
        ,
        .overrun    (overrun)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase, number of bits captured so far, slot contents
    int          m_phase;
    int          m_pos;
    logic [15:0] m_y, m_frame;
    logic        m_ovr;

    typedef struct {
        logic        din;
        logic        dv;
        logic [3:0]  sel;
        logic        ss;
        logic        ab;
        logic        ack;
        logic [15:0] ey;
        logic [3:0]  eidx;
        logic        ebusy;
        logic        edone;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic i_din, i_dv, input logic [3:0] i_sel,
                                input logic i_ss, i_ab, i_ack, input logic [15:0] e_y,
                                input logic [3:0] e_idx, input logic e_busy, e_done);
        vec_t v;
        v.din = i_din; v.dv = i_dv; v.sel = i_sel; v.ss = i_ss; v.ab = i_ab; v.ack = i_ack;
        v.ey = e_y; v.eidx = e_idx; v.ebusy = e_busy; v.edone = e_done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_pos   = 0;
        m_y     = TB_INIT;
        m_frame = 16'h0000;
        m_ovr   = 1'b0;
    endtask

    task automatic model_step(input logic i_din, i_dv, input logic [3:0] i_sel,
                              input logic i_ss, i_ab, i_ack);
        if (i_ack) m_ovr = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (i_ss) begin
                    m_phase = P_SCAN;
                    m_pos   = 0;
                end else if (i_dv) begin
                    m_y[i_sel] = i_din;
                end
            end
            P_SCAN: begin
                if (i_ab) begin
                    m_phase = P_IDLE;
                    m_pos   = 0;
                end else if (i_dv) begin
                    m_y[m_pos] = i_din;
                    m_pos++;
                    if (m_pos == 16) begin
                        m_frame = m_y;
                        m_pos   = 0;
                        m_phase = P_DONE;
                    end
                end
            end
            default: begin
                if (i_ack) begin
                    m_pos   = 0;
                    m_phase = i_ss ? P_SCAN : P_IDLE;
                end else if (i_dv) begin
                    m_ovr = 1'b1;
                end
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_y"},     y,     m_y);
        chk({tag, "_frame"}, frame, m_frame);
        chk({tag, "_idx"},   16'(idx),  16'(m_pos));
        chk({tag, "_busy"},  16'(busy), 16'(m_phase == P_SCAN));
        chk({tag, "_done"},  16'(done), 16'(m_phase == P_DONE));
`ifdef DEMUX16_OVERRUN_EN
        chk({tag, "_ovr"},   16'(overrun), 16'(m_ovr));
`endif
    endtask

    // Apply one cycle of inputs, advance the model at the edge, settle past it
    task automatic cyc(input logic i_din, i_dv, input logic [3:0] i_sel,
                       input logic i_ss, i_ab, i_ack);
        din = i_din; din_valid = i_dv; sel = i_sel;
        scan_start = i_ss; abort = i_ab; done_ack = i_ack;
        @(posedge clk);
        model_step(i_din, i_dv, i_sel, i_ss, i_ab, i_ack);
        #1;
    endtask

    logic [15:0] pat;

    initial begin
        reset_n = 1'b0;
        din = 1'b0; din_valid = 1'b0; sel = 4'd0;
        scan_start = 1'b0; abort = 1'b0; done_ack = 1'b0;
        model_reset();
        #12;
        chk("rst_y", y, TB_INIT);
        chk("rst_frame", frame, 16'h0000);
        chk("rst_idx", 16'(idx), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
`ifdef DEMUX16_OVERRUN_EN
        chk("rst_ovr", 16'(overrun), 16'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // Addressed write, start-wins, 7-bit partial scan, abort with valid, idle abort
        vecs[0]  = mk(1, 1, 4'd5, 0, 0, 0, 16'h0020, 4'd0, 0, 0);
        vecs[1]  = mk(1, 1, 4'd0, 1, 0, 0, 16'h0020, 4'd0, 1, 0);
        vecs[2]  = mk(1, 1, 4'd9, 0, 0, 0, 16'h0021, 4'd1, 1, 0);
        vecs[3]  = mk(1, 1, 4'd9, 0, 0, 0, 16'h0023, 4'd2, 1, 0);
        vecs[4]  = mk(1, 1, 4'd9, 0, 0, 0, 16'h0027, 4'd3, 1, 0);
        vecs[5]  = mk(1, 1, 4'd9, 0, 0, 0, 16'h002F, 4'd4, 1, 0);
        vecs[6]  = mk(1, 1, 4'd9, 0, 0, 0, 16'h003F, 4'd5, 1, 0);
        vecs[7]  = mk(1, 1, 4'd9, 0, 0, 0, 16'h003F, 4'd6, 1, 0);
        vecs[8]  = mk(1, 1, 4'd9, 0, 0, 0, 16'h007F, 4'd7, 1, 0);
        vecs[9]  = mk(1, 1, 4'd9, 0, 1, 0, 16'h007F, 4'd0, 0, 0);
        vecs[10] = mk(0, 0, 4'd0, 0, 1, 0, 16'h007F, 4'd0, 0, 0);
        foreach (vecs[i]) begin
            cyc(vecs[i].din, vecs[i].dv, vecs[i].sel, vecs[i].ss, vecs[i].ab, vecs[i].ack);
            chk($sformatf("vec%0d_y", i), y, vecs[i].ey);
            chk($sformatf("vec%0d_idx", i), 16'(idx), 16'(vecs[i].eidx));
            chk($sformatf("vec%0d_busy", i), 16'(busy), 16'(vecs[i].ebusy));
            chk($sformatf("vec%0d_done", i), 16'(done), 16'(vecs[i].edone));
            chk($sformatf("vec%0d_frame", i), frame, 16'h0000);
        end

        // Full scan of A5C3, LSB first, with random idle gaps
        pat = 16'hA5C3;
        cyc(0, 0, 4'd0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) cyc(0, 0, 4'($urandom), 0, 0, 0);
            cyc(pat[i], 1, 4'($urandom), 0, 0, 0);
        end
        chk("scan_done", 16'(done), 16'h1);
        chk("scan_busy", 16'(busy), 16'h0);
        chk("scan_frame", frame, 16'hA5C3);
        chk("scan_y", y, 16'hA5C3);
        chk("scan_idx", 16'(idx), 16'h0);

        // Valid data and abort while DONE are ignored (overrun flags it when present)
        cyc(0, 1, 4'd3, 0, 1, 0);
        chk("ovr_frame", frame, 16'hA5C3);
        chk("ovr_y", y, 16'hA5C3);
        chk("ovr_done", 16'(done), 16'h1);
`ifdef DEMUX16_OVERRUN_EN
        chk("ovr_set", 16'(overrun), 16'h1);
`endif

        // Back-to-back: acknowledge and restart together, capture 1234
        cyc(0, 0, 4'd0, 1, 0, 1);
        chk("b2b_busy", 16'(busy), 16'h1);
        chk("b2b_done", 16'(done), 16'h0);
        chk("b2b_idx", 16'(idx), 16'h0);
`ifdef DEMUX16_OVERRUN_EN
        chk("ovr_clr", 16'(overrun), 16'h0);
`endif
        pat = 16'h1234;
        for (int i = 0; i < 16; i++) begin
            cyc(pat[i], 1, 4'($urandom), 0, 0, 0);
        end
        chk("b2b_frame", frame, 16'h1234);
        chk("b2b_done2", 16'(done), 16'h1);
        check_model("b2b");
        cyc(0, 0, 4'd0, 0, 0, 1);
        check_model("ack");

        // Reset mid-scan takes effect without a clock edge
        cyc(0, 0, 4'd0, 1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(1'($urandom), 1, 4'd0, 0, 0, 0);
        chk("pre_rst_idx", 16'(idx), 16'h9);
        reset_n = 1'b0;
        #2;
        model_reset();
        chk("mrst_y", y, TB_INIT);
        chk("mrst_idx", 16'(idx), 16'h0);
        chk("mrst_busy", 16'(busy), 16'h0);
        chk("mrst_frame", frame, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1, 1, 4'd2, 0, 0, 0);
        check_model("post_rst");

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            cyc(1'($urandom),
                ($urandom_range(0, 9) < 6),
                4'($urandom),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 4) == 0));
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
